// File: rtl/aes_key_expander.sv
// Word-serial AES-128/192/256 key schedule; clears the key store, then writes round keys 0..Nr in order.
// Optional KEYEXP_REUSE_EN: a repeat request for the last completed key skips the clear and all writes.
module aes_key_expander #(
  parameter int NSLOT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               key_len,
  input  logic [255:0]             key_in,
  output logic                     busy,
  output logic                     done,
  output logic                     reset_valid_bits,
  output logic                     w_en,
  output logic [$clog2(NSLOT)-1:0] waddr,
  output logic [127:0]             wkey
);
  localparam int AW = $clog2(NSLOT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_EXPAND = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_HIT    = 3'd4;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 by an addition chain, followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    b    = gmul(x252, x2);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  logic [2:0]   state;
  logic [1:0]   len_r;
  logic [255:0] key_r;
  logic [5:0]   idx;
  logic [2:0]   kc;
  logic [7:0]   rcon;
  logic [31:0]  win [8];
  logic [95:0]  pack;
  logic         hit;

  logic [5:0]  nk;
  logic [2:0]  nk_m1;
  logic [5:0]  nwords;
  logic [2:0]  kw_sel;
  logic [31:0] key_word, prev, rot_in, sub_out, tmp, w_new;
  logic        is_rot, is_sub;

  always_comb begin
    case (len_r)
      2'b01:   begin nk = 6'd6; nk_m1 = 3'd5; nwords = 6'd52; end
      2'b10:   begin nk = 6'd8; nk_m1 = 3'd7; nwords = 6'd60; end
      default: begin nk = 6'd4; nk_m1 = 3'd3; nwords = 6'd44; end
    endcase
  end

  // win[0] is w[i-1], so win[Nk-1] is w[i-Nk].
  always_comb begin
    kw_sel   = 3'd7 - idx[2:0];
    key_word = key_r[{kw_sel, 5'd0} +: 32];
    prev     = win[0];
    is_rot   = (kc == 3'd0);
    is_sub   = (nk_m1 == 3'd7) && (kc == 3'd4);
    rot_in   = is_rot ? {prev[23:0], prev[31:24]} : prev;
    sub_out  = {sbox(rot_in[31:24]), sbox(rot_in[23:16]), sbox(rot_in[15:8]), sbox(rot_in[7:0])};
    if (is_rot)      tmp = sub_out ^ {rcon, 24'h0};
    else if (is_sub) tmp = sub_out;
    else             tmp = prev;
    w_new = (idx < nk) ? key_word : (win[nk_m1] ^ tmp);
  end

  assign busy             = (state == S_CLEAR) || (state == S_EXPAND) || (state == S_HIT);
  assign done             = (state == S_DONE);
  assign reset_valid_bits = (state == S_CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      len_r <= '0;
      key_r <= '0;
      idx   <= '0;
      kc    <= '0;
      rcon  <= '0;
      pack  <= '0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
      w_en  <= 1'b0;
      waddr <= '0;
      wkey  <= '0;
    end else begin
      w_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_r <= key_len;
            key_r <= key_in;
            state <= hit ? S_HIT : S_CLEAR;
          end
        end
        S_CLEAR: begin
          idx   <= '0;
          kc    <= '0;
          rcon  <= 8'h01;
          state <= S_EXPAND;
        end
        S_EXPAND: begin
          if (idx != nwords) begin
            win[0] <= w_new;
            for (int k = 1; k < 8; k++) win[k] <= win[k-1];
            idx <= idx + 6'd1;
            kc  <= (kc == nk_m1) ? 3'd0 : kc + 3'd1;
            if (is_rot && (idx >= nk))
              rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (idx[1:0] == 2'd3) begin
              w_en  <= 1'b1;
              waddr <= AW'(idx[5:2]);
              wkey  <= {pack, w_new};
            end else begin
              pack <= {pack[63:0], w_new};
            end
          end else begin
            state <= S_DONE;
          end
        end
        S_HIT:   state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KEYEXP_REUSE_EN
  logic         cache_vld;
  logic [1:0]   cache_len;
  logic [255:0] cache_key;

  assign hit = cache_vld && (key_len == cache_len) && (key_in == cache_key);

  // Only a run that reaches its final write is remembered; reset drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_vld <= 1'b0;
      cache_len <= '0;
      cache_key <= '0;
    end else if ((state == S_EXPAND) && (idx == nwords)) begin
      cache_vld <= 1'b1;
      cache_len <= len_r;
      cache_key <= key_r;
    end
  end
`else
  assign hit = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench: a word-array key schedule model drives a per-cycle compare of every output.
module tb_aes_key_expander;
  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, done, reset_valid_bits, w_en;
  logic [3:0]   waddr;
  logic [127:0] wkey;

  always #5 clk = ~clk;

  aes_key_expander #(.NSLOT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .reset_valid_bits(reset_valid_bits),
    .w_en(w_en), .waddr(waddr), .wkey(wkey)
  );

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KEY2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [15];
  int           exp_nr = 10;
  bit           exp_hit = 1'b0;
  int           go_id = 0;
  int           pin_n = 0;
  int           pin_slot [2];
  logic [127:0] pin_val [2];
  int           pin_lat = 0;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa, bb;
    r = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) r = r ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic model(input logic [1:0] len, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, tot;
    nk = (len == 2'b01) ? 6 : (len == 2'b10) ? 8 : 4;
    exp_nr = nk + 6;
    tot = 4 * (exp_nr + 1);
    rc = 8'h01;
    for (int i = 0; i < tot; i++) begin
      if (i < nk) w[i] = key[255 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk == 8 && i % 8 == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int s = 0; s <= exp_nr; s++) exp_rk[s] = {w[4*s], w[4*s+1], w[4*s+2], w[4*s+3]};
  endtask

  // ---------------- compare process ----------------
  int           n_vec = 0, n_err = 0;
  int           seen_go = 0, k = 0, done_k = -1;
  bit           active = 1'b0;
  logic [3:0]   last_addr = 4'd0;
  logic [127:0] last_key = '0;
  logic [127:0] got [15];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (run cycle %0d)", nm, act, expv, k);
    end
  endtask

  always @(negedge clk) begin
    logic eb, ed, er, ew;
    if (!reset) begin
      active = 1'b0; last_addr = 4'd0; last_key = '0; seen_go = go_id;
      chk("reset_ctrl", 128'({busy, done, reset_valid_bits, w_en}), 128'd0);
      chk("reset_waddr", 128'(waddr), 128'd0);
      chk("reset_wkey", wkey, 128'd0);
    end else begin
      if (go_id != seen_go) begin
        seen_go = go_id; active = 1'b1; k = 0; done_k = -1;
        for (int s = 0; s < 15; s++) got[s] = '0;
      end
      eb = 1'b0; ed = 1'b0; er = 1'b0; ew = 1'b0;
      if (active) begin
        k++;
        if (exp_hit) begin
          eb = (k == 1); ed = (k == 2);
        end else begin
          er = (k == 1);
          eb = (k >= 1) && (k <= 4*exp_nr + 6);
          ed = (k == 4*exp_nr + 7);
          if (k >= 6 && (k - 6) % 4 == 0 && (k - 6) / 4 <= exp_nr) begin
            ew = 1'b1;
            last_addr = 4'((k - 6) / 4);
            last_key  = exp_rk[(k - 6) / 4];
          end
        end
      end
      chk("ctrl{busy,done,rvb,w_en}", 128'({busy, done, reset_valid_bits, w_en}), 128'({eb, ed, er, ew}));
      chk("waddr", 128'(waddr), 128'(last_addr));
      chk("wkey", wkey, last_key);
      if (w_en && waddr < 4'd15) got[waddr] = wkey;
      if (active && done && done_k < 0) done_k = k;
      if (active && ed) begin
        active = 1'b0;
        chk("latency", 128'(done_k), 128'(pin_lat));
        for (int p = 0; p < pin_n; p++)
          chk($sformatf("slot%0d", pin_slot[p]), got[pin_slot[p]], pin_val[p]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_pins(input int n, input int s0, input logic [127:0] v0,
                          input int s1, input logic [127:0] v1, input int lat);
    pin_n = n; pin_slot[0] = s0; pin_val[0] = v0; pin_slot[1] = s1; pin_val[1] = v1; pin_lat = lat;
  endtask

  task automatic launch(input logic [1:0] len, input logic [255:0] key, input bit hit);
    @(posedge clk); #1;
    key_len = len; key_in = key; start = 1'b1;
    model(len, key);
    exp_hit = hit;
    @(posedge clk); #1;
    start = 1'b0;
    go_id++;
  endtask

  initial begin
    logic [7:0] inv, s, c;
    reset = 1'b0; start = 1'b0; key_len = 2'b00; key_in = '0;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int j = 0; j < 8; j++)
        s[j] = inv[j] ^ inv[(j+4)%8] ^ inv[(j+5)%8] ^ inv[(j+6)%8] ^ inv[(j+7)%8] ^ c[j];
      sb[x] = s;
    end
    repeat (3) @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // AES-128
    set_pins(2, 1, 128'ha0fafe1788542cb123a339392a6c7605, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 47);
    launch(2'b00, {KEY1, 128'h0}, 1'b0);
    repeat (55) @(posedge clk);

    // AES-192
    set_pins(1, 12, 128'he98ba06f448c773c8ecc720401002202, 0, '0, 55);
    launch(2'b01, {KEY2, 64'h0}, 1'b0);
    repeat (62) @(posedge clk);

    // AES-256
    set_pins(1, 14, 128'hfe4890d1e6188d0b046df344706c631e, 0, '0, 63);
    launch(2'b10, KEY3, 1'b0);
    repeat (70) @(posedge clk);

    // AES-128 with a second start (and different key on the bus) mid-run
    set_pins(2, 1, 128'ha0fafe1788542cb123a339392a6c7605, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 47);
    launch(2'b00, {KEY1, 128'h0}, 1'b0);
    repeat (19) @(posedge clk); #1;
    start = 1'b1; key_len = 2'b10; key_in = KEY3;
    @(posedge clk); #1;
    start = 1'b0; key_len = 2'b00; key_in = {KEY1, 128'h0};
    repeat (35) @(posedge clk);

    // AES-256 aborted by reset during the slot-5 write, then a clean AES-128 run
    set_pins(0, 0, '0, 0, '0, 63);
    launch(2'b10, KEY3, 1'b0);
    repeat (25) @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    set_pins(2, 1, 128'ha0fafe1788542cb123a339392a6c7605, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 47);
    launch(2'b00, {KEY1, 128'h0}, 1'b0);
    repeat (55) @(posedge clk);

    // Same key again: cache hit when reuse is built in, full run otherwise
`ifdef KEYEXP_REUSE_EN
    set_pins(0, 0, '0, 0, '0, 2);
    launch(2'b00, {KEY1, 128'h0}, 1'b1);
    repeat (8) @(posedge clk);
`else
    set_pins(2, 1, 128'ha0fafe1788542cb123a339392a6c7605, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 47);
    launch(2'b00, {KEY1, 128'h0}, 1'b0);
    repeat (55) @(posedge clk);
`endif

    // One key bit flipped: always a full run
    set_pins(1, 0, KEY1 ^ 128'h1, 0, '0, 47);
    launch(2'b00, {KEY1 ^ 128'h1, 128'h0}, 1'b0);
    repeat (55) @(posedge clk);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
